// File: rtl/vram_host_sched.sv
// ---------------------------------------------------------------------------
// vram_host_sched
//
// Host-side access scheduler for the VRAM block.
//
// Host commands enter through a valid/ready handshake and wait in a small
// in-order FIFO. Commands are issued to VRAM's shared host port one at a time:
//   - A write drives hostAddr/vramWrData with a one-cycle vramWr strobe.
//   - A read drives hostAddr and holds it for a fixed worst-case interval.
//     That interval covers VRAM's alternating-cycle read-port multiplexing.
//     The read then captures hostData and pulses rdValid for one cycle.
//
// Ports
//   clk, nrst            clock, synchronous active-low reset
//   cmdValid/cmdReady    command handshake (cmdReady = FIFO not full)
//   cmdWrite             1 = write, 0 = read
//   cmdAddr, cmdWrData   command address (13b) and write data (8b)
//   rdValid, rdData      one-cycle read-complete pulse and held read data
//   busy                 FIFO non-empty, read in flight, or write strobing
//   hostAddr             VRAM host address
//   vramWrData, vramWr   VRAM write data and write strobe
//   hostData             VRAM host read data
// ---------------------------------------------------------------------------
module vram_host_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int READ_WAIT  = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdWrite,
  input  logic [12:0] cmdAddr,
  input  logic [7:0]  cmdWrData,
  output logic        rdValid,
  output logic [7:0]  rdData,
  output logic        busy,
  output logic [12:0] hostAddr,
  output logic [7:0]  vramWrData,
  output logic        vramWr,
  input  logic [7:0]  hostData
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(READ_WAIT) + 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(READ_WAIT - 1);

  typedef struct packed {
    logic        wr;
    logic [12:0] addr;
    logic [7:0]  data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_CAPT
  } state_t;

  cmd_t          fifo_q [FIFO_DEPTH];
  cmd_t          fifo_d [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [12:0]   host_addr_q, host_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          vram_wr_q, vram_wr_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  cmd_t          head;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bits means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push  = cmdValid && !full;
  assign head  = fifo_q[rd_ptr_q[PW-1:0]];

  // The issue slot is free in IDLE and on the capture edge of a read, so a
  // queued command follows a read without a bubble.
  assign pop = !empty && ((state_q == IDLE) || (state_q == RD_CAPT));

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q[PW-1:0]] = '{wr: cmdWrite, addr: cmdAddr, data: cmdWrData};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // hostAddr and vramWrData keep their last values when nothing issues.
  // A read loads the counter with READ_WAIT-1. RD_WAIT counts it down to
  // zero, so hostData is sampled READ_WAIT+1 edges after issue.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    host_addr_d = host_addr_q;
    wr_data_d   = wr_data_q;
    vram_wr_d   = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;

    case (state_q)
      IDLE: begin
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = RD_CAPT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_CAPT: begin
        rd_data_d  = hostData;
        rd_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      host_addr_d = head.addr;
      if (head.wr) begin
        wr_data_d = head.data;
        vram_wr_d = 1'b1;
      end else begin
        cnt_d   = WAIT_LOAD;
        state_d = RD_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      host_addr_q <= '0;
      wr_data_q   <= '0;
      vram_wr_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      host_addr_q <= host_addr_d;
      wr_data_q   <= wr_data_d;
      vram_wr_q   <= vram_wr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign cmdReady   = !full;
  assign rdValid    = rd_valid_q;
  assign rdData     = rd_data_q;
  assign hostAddr   = host_addr_q;
  assign vramWrData = wr_data_q;
  assign vramWr     = vram_wr_q;
  assign busy       = !empty || (state_q != IDLE) || vram_wr_q;

endmodule

// File: tb/tb_vram_host_sched.sv
// ---------------------------------------------------------------------------
// tb_vram_host_sched
//
// Testbench for vram_host_sched.
//
// The bench contains three models:
//   - A VRAM stand-in whose read port updates hostData only on alternate
//     cycles. Read data therefore appears 1 or 2 cycles after an address
//     change.
//   - A transaction-level reference model: a command queue plus a
//     "read busy for N more edges" counter. It predicts every output each
//     cycle.
//   - A table of directed vectors and hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_vram_host_sched;

  localparam int FIFO_DEPTH = 4;
  localparam int READ_WAIT  = 2;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdWrite = 1'b0;
  logic [12:0] cmdAddr = '0;
  logic [7:0]  cmdWrData = '0;
  logic        cmdReady;
  logic        rdValid;
  logic [7:0]  rdData;
  logic        busy;
  logic [12:0] hostAddr;
  logic [7:0]  vramWrData;
  logic        vramWr;
  logic [7:0]  hostData;

  always #5 clk = ~clk;

  vram_host_sched #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .READ_WAIT (READ_WAIT)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cmdValid  (cmdValid),
    .cmdReady  (cmdReady),
    .cmdWrite  (cmdWrite),
    .cmdAddr   (cmdAddr),
    .cmdWrData (cmdWrData),
    .rdValid   (rdValid),
    .rdData    (rdData),
    .busy      (busy),
    .hostAddr  (hostAddr),
    .vramWrData(vramWrData),
    .vramWr    (vramWr),
    .hostData  (hostData)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Power-up contents of VRAM that has never been written.
  function automatic logic [7:0] init_byte(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h5A;
  endfunction

  // VRAM stand-in. The host read port is serviced only on alternate cycles.
  logic [7:0] vram_mem [8192];
  bit         vram_written [8192];
  logic [7:0] host_data_q = 8'h00;
  bit         phase = 1'b0;
  int         cyc = 0;

  assign hostData = host_data_q;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    phase <= ~phase;
    if (phase) begin
      host_data_q <= vram_written[hostAddr] ? vram_mem[hostAddr] : init_byte(hostAddr);
    end
    if (vramWr === 1'b1) begin
      vram_mem[hostAddr]     <= vramWrData;
      vram_written[hostAddr] <= 1'b1;
    end
  end

  // Reference model. A read keeps the issue slot for READ_WAIT+1 edges. The
  // edge on which that count expires delivers the data and may also issue
  // the next queued command.
  typedef struct {
    bit          wr;
    logic [12:0] addr;
    logic [7:0]  data;
  } mcmd_t;

  mcmd_t       m_q[$];
  logic [7:0]  model_mem [8192];
  bit          model_written [8192];
  int          m_read_left = 0;
  logic [12:0] m_read_addr = '0;
  logic [12:0] m_host_addr = '0;
  logic [7:0]  m_wr_data = '0;
  logic [7:0]  m_rd_data = '0;
  bit          m_vram_wr = 1'b0;
  bit          m_rd_valid = 1'b0;
  bit          check_en = 1'b0;

  always @(posedge clk) begin
    bit    accept;
    mcmd_t c;
    check_en = 1'b1;
    if (!nrst) begin
      m_q.delete();
      m_read_left = 0;
      m_host_addr = '0;
      m_wr_data   = '0;
      m_rd_data   = '0;
      m_vram_wr   = 1'b0;
      m_rd_valid  = 1'b0;
    end else begin
      accept     = cmdValid && (m_q.size() < FIFO_DEPTH);
      m_vram_wr  = 1'b0;
      m_rd_valid = 1'b0;
      if (m_read_left > 0) begin
        m_read_left--;
        if (m_read_left == 0) begin
          m_rd_valid = 1'b1;
          m_rd_data  = model_written[m_read_addr] ? model_mem[m_read_addr]
                                                  : init_byte(m_read_addr);
        end
      end
      if (m_read_left == 0 && m_q.size() > 0) begin
        c = m_q.pop_front();
        m_host_addr = c.addr;
        if (c.wr) begin
          m_vram_wr             = 1'b1;
          m_wr_data             = c.data;
          model_mem[c.addr]     = c.data;
          model_written[c.addr] = 1'b1;
        end else begin
          m_read_left = READ_WAIT + 1;
          m_read_addr = c.addr;
        end
      end
      if (accept) begin
        m_q.push_back('{wr: cmdWrite, addr: cmdAddr, data: cmdWrData});
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("cmdReady", 32'(cmdReady), 32'(m_q.size() < FIFO_DEPTH));
      check_output("busy", 32'(busy),
                   32'((m_q.size() != 0) || (m_read_left != 0) || m_vram_wr));
      check_output("vramWr", 32'(vramWr), 32'(m_vram_wr));
      check_output("hostAddr", 32'(hostAddr), 32'(m_host_addr));
      check_output("vramWrData", 32'(vramWrData), 32'(m_wr_data));
      check_output("rdValid", 32'(rdValid), 32'(m_rd_valid));
      check_output("rdData", 32'(rdData), 32'(m_rd_data));
    end
  end

  // Log of observed read completions and the longest vramWr run.
  logic [7:0] rd_log[$];
  int         rd_cyc[$];
  int         wr_run = 0;
  int         wr_run_max = 0;

  always @(negedge clk) begin
    if (rdValid === 1'b1) begin
      rd_log.push_back(rdData);
      rd_cyc.push_back(cyc);
    end
    if (vramWr === 1'b1) begin
      wr_run++;
      if (wr_run > wr_run_max) wr_run_max = wr_run;
    end else begin
      wr_run = 0;
    end
  end

  // Present one command and hold it until the DUT takes it.
  task automatic apply_stimulus(input bit wr, input logic [12:0] addr, input logic [7:0] data);
    bit acc = 1'b0;
    cmdValid  = 1'b1;
    cmdWrite  = wr;
    cmdAddr   = addr;
    cmdWrData = data;
    for (int n = 0; n < 64 && !acc; n++) begin
      acc = cmdReady;
      @(negedge clk);
    end
    cmdValid = 1'b0;
    if (!acc) check_output("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_q.size() != 0 || m_read_left != 0 || m_rd_valid || m_vram_wr) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_output("idle_timeout", 32'd0, 32'd1);
  endtask

  // Counts negedges until rdValid is seen (bounded).
  task automatic wait_rd(output int lat);
    lat = 0;
    while (rdValid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] wdat [8];

  initial begin
    int lat;
    int n;
    int base;
    logic [12:0] a;

    vecs[0] = '{1'b1, 13'h1234, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 13'h1234, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 13'h0000, 8'h3C, 8'h00};
    vecs[3] = '{1'b0, 13'h0000, 8'h00, 8'h3C};
    vecs[4] = '{1'b1, 13'h1FFF, 8'hFF, 8'h00};
    vecs[5] = '{1'b0, 13'h1FFF, 8'h00, 8'hFF};
    vecs[6] = '{1'b0, 13'h0010, 8'h00, init_byte(13'h0010)};
    vecs[7] = '{1'b1, 13'h0010, 8'h00, 8'h00};
    vecs[8] = '{1'b0, 13'h0010, 8'h00, 8'h00};

    // Reset held with a command presented: nothing may be accepted.
    $display("[TB] reset with cmdValid asserted");
    nrst      = 1'b0;
    cmdValid  = 1'b1;
    cmdWrite  = 1'b1;
    cmdAddr   = 13'h0555;
    cmdWrData = 8'h77;
    repeat (3) @(negedge clk);
    check_output("rst_cmdReady", 32'(cmdReady), 32'd1);
    check_output("rst_vramWr", 32'(vramWr), 32'd0);
    check_output("rst_rdValid", 32'(rdValid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_hostAddr", 32'(hostAddr), 32'd0);
    cmdValid = 1'b0;
    nrst     = 1'b1;
    @(negedge clk);
    check_output("post_rst_cmdReady", 32'(cmdReady), 32'd1);
    check_output("post_rst_busy", 32'(busy), 32'd0);

    // Directed vector table.
    $display("[TB] directed vectors");
    for (int i = 0; i < 9; i++) begin
      wait_idle();
      apply_stimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].wr) begin
        n = 0;
        while (vramWr !== 1'b1 && n < 10) begin
          @(negedge clk);
          n++;
        end
        check_output($sformatf("vec%0d_wr_addr", i), 32'(hostAddr), 32'(vecs[i].addr));
        check_output($sformatf("vec%0d_wr_data", i), 32'(vramWrData), 32'(vecs[i].wdata));
      end else begin
        wait_rd(lat);
        check_output($sformatf("vec%0d_rd_latency", i), 32'(lat), 32'd4);
        check_output($sformatf("vec%0d_rd_data", i), 32'(rdData), 32'(vecs[i].exp_rd));
      end
    end

    // Same read started on both cycle parities of the VRAM port toggle.
    $display("[TB] read-port toggle phase");
    for (int p = 0; p < 2; p++) begin
      wait_idle();
      if ((cyc % 2) != p) @(negedge clk);
      apply_stimulus(1'b0, 13'h0ABC, 8'h00);
      wait_rd(lat);
      check_output($sformatf("phase%0d_latency", p), 32'(lat), 32'd4);
      check_output($sformatf("phase%0d_data", p), 32'(rdData), 32'(init_byte(13'h0ABC)));
    end

    // Continuous reads fill the FIFO; the sixth accept leaves it full.
    $display("[TB] fifo full and drain order");
    wait_idle();
    base = rd_log.size();
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1'b0, 13'h0400 + 13'(k * 3), 8'h00);
      if (k == 5) check_output("fifo_full_ready", 32'(cmdReady), 32'd0);
    end
    wait_idle();
    check_output("fifo_drain_count", 32'(rd_log.size() - base), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < rd_log.size()) begin
        check_output($sformatf("fifo_drain%0d", k), 32'(rd_log[base + k]),
                     32'(init_byte(13'h0400 + 13'(k * 3))));
      end
    end

    // Eight writes at full rate, then eight reads of the same addresses.
    $display("[TB] back-to-back writes then reads");
    wait_idle();
    base = rd_log.size();
    for (int k = 0; k < 8; k++) begin
      wdat[k] = 8'($urandom);
      apply_stimulus(1'b1, 13'h0200 + 13'(k * 37), wdat[k]);
    end
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1'b0, 13'h0200 + 13'(k * 37), 8'h00);
    end
    wait_idle();
    check_output("b2b_wr_run", 32'(wr_run_max), 32'd8);
    check_output("b2b_rd_count", 32'(rd_log.size() - base), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < rd_log.size()) begin
        check_output($sformatf("b2b_rd%0d", k), 32'(rd_log[base + k]), 32'(wdat[k]));
        if (k > 0) begin
          check_output($sformatf("b2b_gap%0d", k),
                       32'(rd_cyc[base + k] - rd_cyc[base + k - 1]), 32'd3);
        end
      end
    end

    // Reset while a read waits, with a write queued behind it.
    $display("[TB] reset during read wait");
    wait_idle();
    base = rd_log.size();
    apply_stimulus(1'b0, 13'h0300, 8'h00);
    apply_stimulus(1'b1, 13'h0300, 8'hEE);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    check_output("midrd_busy_in_rst", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    check_output("midrd_no_rdValid", 32'(rd_log.size() - base), 32'd0);
    check_output("midrd_busy_after", 32'(busy), 32'd0);
    apply_stimulus(1'b0, 13'h0300, 8'h00);
    wait_rd(lat);
    check_output("midrd_next_latency", 32'(lat), 32'd4);
    check_output("midrd_next_data", 32'(rdData), 32'(init_byte(13'h0300)));

    // Random mix over a small address pool to provoke read-after-write.
    $display("[TB] randomized traffic");
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = 13'h0600 + 13'($urandom_range(0, 7) * 5);
      apply_stimulus(1'($urandom_range(0, 1)), a, 8'($urandom));
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
